// File: rtl/piso_pkg.sv
// Shared definitions for the piso_stream parallel-in/serial-out converter:
// FSM state encoding, a constant clog2 and the slice-count normalisation.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } piso_state_e;

  function automatic int piso_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // A count of zero, or one larger than a full word, means "send the whole word".
  function automatic logic [31:0] piso_norm_count(input logic [31:0] count,
                                                  input logic [31:0] num_words);
    if ((count == 32'd0) || (count > num_words)) begin
      return num_words;
    end
    return count;
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register for a word and its slice count.
// load captures a new entry (and wins over take); take empties the entry.
module piso_hold_buf
  import piso_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic              take,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  count_in,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (load) begin
      data  <= data_in;
      count <= count_in;
      full  <= 1'b1;
    end else if (take) begin
      data  <= '0;
      count <= '0;
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out converter, LSB slice first, with a one-word holding
// buffer for bubble-free streaming. Define PISO_LAST_EN to add the OUT_LAST port.
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready are
// both high; valid never depends on ready, and IN_READY is a pure state decode.
module piso_stream
  import piso_pkg::*;
#(
  parameter int  DATA_IN_WIDTH  = 64,
  parameter int  DATA_OUT_WIDTH = 16,
  localparam int NUM_WORDS      = DATA_IN_WIDTH / DATA_OUT_WIDTH,
  localparam int CNT_W          = piso_clog2(NUM_WORDS) + 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [DATA_IN_WIDTH-1:0]  DATA_IN,
  input  logic [CNT_W-1:0]          IN_COUNT,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [DATA_OUT_WIDTH-1:0] DATA_OUT
`ifdef PISO_LAST_EN
  ,
  output logic                      OUT_LAST
`endif
);

  if ((DATA_IN_WIDTH % DATA_OUT_WIDTH) != 0 || NUM_WORDS < 2) begin : g_cfg_err
    $error("piso_stream: DATA_IN_WIDTH must be a multiple (>=2x) of DATA_OUT_WIDTH");
  end

  piso_state_e              state;
  piso_state_e              state_next;
  logic [DATA_IN_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]         rem;
  logic [CNT_W-1:0]         eff_count;

  logic [DATA_IN_WIDTH-1:0] buf_data;
  logic [CNT_W-1:0]         buf_count;
  logic                     buf_full;

  logic in_fire;
  logic out_fire;
  logic last_pop;

  // FSM command strobes
  logic load_in;
  logic load_buf;
  logic shift_en;
  logic clear_sr;
  logic buf_load;
  logic buf_take;

  assign eff_count = CNT_W'(piso_norm_count(32'(IN_COUNT), 32'(NUM_WORDS)));

  assign IN_READY  = (state != ST_FULL);
  assign OUT_VALID = (state != ST_EMPTY);
  assign DATA_OUT  = shift_reg[DATA_OUT_WIDTH-1:0];

`ifdef PISO_LAST_EN
  assign OUT_LAST = OUT_VALID & (rem == CNT_W'(1));
`endif

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = OUT_VALID & OUT_READY;
  assign last_pop = out_fire & (rem == CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_in    = 1'b0;
    load_buf   = 1'b0;
    shift_en   = 1'b0;
    clear_sr   = 1'b0;
    buf_load   = 1'b0;
    buf_take   = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_in    = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (in_fire && last_pop) begin
          load_in = 1'b1;
        end else if (in_fire) begin
          buf_load   = 1'b1;
          shift_en   = out_fire;
          state_next = ST_FULL;
        end else if (last_pop) begin
          clear_sr   = 1'b1;
          state_next = ST_EMPTY;
        end else begin
          shift_en = out_fire;
        end
      end
      ST_FULL: begin
        // IN_VALID is ignored here; IN_READY is low so nothing can fire.
        if (last_pop) begin
          load_buf   = 1'b1;
          buf_take   = 1'b1;
          state_next = ST_SHIFT;
        end else begin
          shift_en = out_fire;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shift_reg <= '0;
      rem       <= '0;
    end else if (load_in) begin
      shift_reg <= DATA_IN;
      rem       <= eff_count;
    end else if (load_buf) begin
      shift_reg <= buf_data;
      rem       <= buf_count;
    end else if (clear_sr) begin
      shift_reg <= '0;
      rem       <= '0;
    end else if (shift_en) begin
      shift_reg <= shift_reg >> DATA_OUT_WIDTH;
      rem       <= rem - CNT_W'(1);
    end
  end

  piso_hold_buf #(
    .DATA_W (DATA_IN_WIDTH),
    .CNT_W  (CNT_W)
  ) u_hold_buf (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (buf_load),
    .take     (buf_take),
    .data_in  (DATA_IN),
    .count_in (eff_count),
    .data     (buf_data),
    .count    (buf_count),
    .full     (buf_full)
  );

  // The buffer flag and the FULL state must always agree outside reset.
  always_comb begin
    if (!RESET) begin
      assert ((state == ST_FULL) == buf_full)
        else $error("piso_stream: buffer flag disagrees with FSM state");
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Directed, table-driven bench for piso_stream at 64/16 (four slices per word),
// plus hand sequences for reset-mid-word and random backpressure ordering.
module tb_piso_stream;

  localparam int DIN_W  = 64;
  localparam int DOUT_W = 16;
  localparam int CNT_W  = 3;
  localparam int NWORDS = 4;

  logic              CLK;
  logic              RESET;
  logic              IN_VALID;
  logic              IN_READY;
  logic [DIN_W-1:0]  DATA_IN;
  logic [CNT_W-1:0]  IN_COUNT;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DOUT_W-1:0] DATA_OUT;
`ifdef PISO_LAST_EN
  logic              OUT_LAST;
`endif

  int total = 0;
  int bad   = 0;

  piso_stream #(
    .DATA_IN_WIDTH  (DIN_W),
    .DATA_OUT_WIDTH (DOUT_W)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DATA_IN   (DATA_IN),
    .IN_COUNT  (IN_COUNT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .DATA_OUT  (DATA_OUT)
`ifdef PISO_LAST_EN
    ,
    .OUT_LAST  (OUT_LAST)
`endif
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic              rst;
    logic              iv;
    logic [DIN_W-1:0]  din;
    logic [CNT_W-1:0]  cnt;
    logic              ordy;
    logic              ov;
    logic              ir;
    logic [DOUT_W-1:0] dout;
    logic              last;
  } vec_t;

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t row(input logic iv, input logic [DIN_W-1:0] din,
                               input logic [CNT_W-1:0] cnt, input logic ordy,
                               input logic ov, input logic ir,
                               input logic [DOUT_W-1:0] dout, input logic last);
    vec_t v;
    v.rst = 1'b0; v.iv = iv; v.din = din; v.cnt = cnt; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.dout = dout; v.last = last;
    return v;
  endfunction

  // Drive one cycle's inputs, check the registered outputs of that cycle, clock.
  task automatic apply_row(input vec_t v, input string tag);
    RESET     = v.rst;
    IN_VALID  = v.iv;
    DATA_IN   = v.din;
    IN_COUNT  = v.cnt;
    OUT_READY = v.ordy;
    check({tag, ".out_valid"}, 64'(OUT_VALID), 64'(v.ov));
    check({tag, ".in_ready"}, 64'(IN_READY), 64'(v.ir));
    if (v.ov) check({tag, ".data_out"}, 64'(DATA_OUT), 64'(v.dout));
`ifdef PISO_LAST_EN
    check({tag, ".out_last"}, 64'(OUT_LAST), 64'(v.last));
`endif
    @(posedge CLK);
    #1;
  endtask

  // ---------------- scoreboard state ----------------
  logic [DOUT_W:0] exp_q[$];
  vec_t            tbl[$];

  localparam logic [63:0] W2 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] WA = 64'hA003_A002_A001_A000;
  localparam logic [63:0] WB = 64'hB003_B002_B001_B000;
  localparam logic [63:0] WC = 64'hC003_C002_C001_C000;
  localparam logic [63:0] WE = 64'hE003_E002_E001_E000;
  localparam logic [63:0] WF = 64'hF003_F002_F001_F000;
  localparam logic [63:0] WG = 64'h0004_0003_0002_0001;
  localparam logic [63:0] WH = 64'h5553_5552_5551_5550;
  localparam logic [63:0] WI = 64'h6663_6662_6661_6660;
  localparam logic [63:0] WJ = 64'h7773_7772_7771_7770;

  initial begin
    vec_t v;
    RESET = 1'b1; IN_VALID = 1'b0; DATA_IN = '0; IN_COUNT = '0; OUT_READY = 1'b0;

    // ---- reset ----
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("reset.out_valid", 64'(OUT_VALID), 64'd0);
    check("reset.in_ready", 64'(IN_READY), 64'd1);
    check("reset.data_out", 64'(DATA_OUT), 64'd0);
`ifdef PISO_LAST_EN
    check("reset.out_last", 64'(OUT_LAST), 64'd0);
`endif

    // ---- table: single word, back-to-back, short words, overflow count, hold ----
    tbl.push_back(row(1, W2, 0, 1, 0, 1, 16'h0000, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'h1111, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'h2222, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'h3333, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'h4444, 1));
    tbl.push_back(row(1, WA, 4, 1, 0, 1, 16'h0000, 0));
    tbl.push_back(row(1, WB, 4, 1, 1, 1, 16'hA000, 0));
    tbl.push_back(row(1, WC, 4, 1, 1, 0, 16'hA001, 0));
    tbl.push_back(row(1, WC, 4, 1, 1, 0, 16'hA002, 0));
    tbl.push_back(row(1, WC, 4, 1, 1, 0, 16'hA003, 1));
    tbl.push_back(row(1, WC, 4, 1, 1, 1, 16'hB000, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 0, 16'hB001, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 0, 16'hB002, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 0, 16'hB003, 1));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'hC000, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'hC001, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'hC002, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'hC003, 1));
    tbl.push_back(row(1, 64'h1111_2222_3333_D000, 1, 1, 0, 1, 16'h0000, 0));
    tbl.push_back(row(1, 64'h1111_2222_3333_D001, 1, 1, 1, 1, 16'hD000, 1));
    tbl.push_back(row(1, 64'h1111_2222_3333_D002, 1, 1, 1, 1, 16'hD001, 1));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'hD002, 1));
    tbl.push_back(row(1, WE, 2, 1, 0, 1, 16'h0000, 0));
    tbl.push_back(row(1, WF, 7, 1, 1, 1, 16'hE000, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 0, 16'hE001, 1));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'hF000, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'hF001, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'hF002, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'hF003, 1));
    tbl.push_back(row(1, WG, 3, 1, 0, 1, 16'h0000, 0));
    tbl.push_back(row(0, '0, 0, 0, 1, 1, 16'h0001, 0));
    tbl.push_back(row(0, '0, 0, 0, 1, 1, 16'h0001, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'h0001, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'h0002, 0));
    tbl.push_back(row(0, '0, 0, 1, 1, 1, 16'h0003, 1));
    tbl.push_back(row(0, '0, 0, 1, 0, 1, 16'h0000, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply_row(tbl[i], $sformatf("tbl[%0d]", i));
    end

    // ---- reset mid-word with the buffer full ----
    apply_row(row(1, WH, 0, 1, 0, 1, 16'h0000, 0), "rst_mid.h0");
    apply_row(row(1, WI, 0, 1, 1, 1, 16'h5550, 0), "rst_mid.h1");
    v = row(0, '0, 0, 0, 1, 0, 16'h5551, 0);
    v.rst = 1'b1;
    apply_row(v, "rst_mid.h2");
    apply_row(row(0, '0, 0, 1, 0, 1, 16'h0000, 0), "rst_mid.h3");
    apply_row(row(0, '0, 0, 1, 0, 1, 16'h0000, 0), "rst_mid.h4");
    apply_row(row(1, WJ, 4, 1, 0, 1, 16'h0000, 0), "rst_mid.h5");
    apply_row(row(0, '0, 0, 1, 1, 1, 16'h7770, 0), "rst_mid.h6");
    apply_row(row(0, '0, 0, 1, 1, 1, 16'h7771, 0), "rst_mid.h7");
    apply_row(row(0, '0, 0, 1, 1, 1, 16'h7772, 0), "rst_mid.h8");
    apply_row(row(0, '0, 0, 1, 1, 1, 16'h7773, 1), "rst_mid.h9");
    apply_row(row(0, '0, 0, 1, 0, 1, 16'h0000, 0), "rst_mid.h10");

    // ---- random backpressure, scoreboard ordering ----
    begin
      logic [DIN_W-1:0]  words[12];
      logic [CNT_W-1:0]  cnts[12];
      int                sent;
      int                cycles;
      logic              prev_stall;
      logic [DOUT_W-1:0] prev_data;
      logic [DOUT_W:0]   exp_e;
      for (int i = 0; i < 12; i++) begin
        words[i] = {$urandom, $urandom};
        cnts[i]  = CNT_W'($urandom_range(0, 7));
      end
      sent = 0;
      cycles = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      while ((sent < 12 || exp_q.size() != 0) && cycles < 3000) begin
        IN_VALID  = (sent < 12) && ($urandom_range(0, 3) != 0);
        DATA_IN   = (sent < 12) ? words[sent] : '0;
        IN_COUNT  = (sent < 12) ? cnts[sent] : '0;
        OUT_READY = 1'($urandom_range(0, 1));
        if (prev_stall) begin
          check("rand.hold_valid", 64'(OUT_VALID), 64'd1);
          check("rand.hold_data", 64'(DATA_OUT), 64'(prev_data));
        end
        if (IN_VALID && IN_READY) begin
          int n;
          n = (cnts[sent] == 0 || cnts[sent] > NWORDS) ? NWORDS : int'(cnts[sent]);
          for (int s = 0; s < n; s++) begin
            exp_q.push_back({(s == n - 1), words[sent][s*DOUT_W +: DOUT_W]});
          end
          sent++;
        end
        if (OUT_VALID && OUT_READY) begin
          if (exp_q.size() == 0) begin
            check("rand.unexpected_slice", 64'(DATA_OUT), 64'hDEAD_0000_0000_0000);
          end else begin
            exp_e = exp_q.pop_front();
            check("rand.data", 64'(DATA_OUT), 64'(exp_e[DOUT_W-1:0]));
`ifdef PISO_LAST_EN
            check("rand.last", 64'(OUT_LAST), 64'(exp_e[DOUT_W]));
`endif
          end
        end
        prev_stall = OUT_VALID && !OUT_READY;
        prev_data  = DATA_OUT;
        @(posedge CLK);
        #1;
        cycles++;
      end
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      check("rand.words_sent", 64'(sent), 64'd12);
      check("rand.queue_drained", 64'(exp_q.size()), 64'd0);
      check("rand.end_empty", 64'(OUT_VALID), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
